// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Operand-issue / result handshake bundle for alu_seq.
//            The master drives operands and accepts results.
//            The slave (the ALU) consumes operands and produces results.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, cout, zero
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, cout, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : WIDTH-generic handshaked ALU. ADD/SUB/AND/OR/XOR complete in
//            one cycle. MUL (shift-add) and DIV (restoring) iterate once per
//            clock for WIDTH clocks. Macro ALU_REM_EN turns opcode 111 into
//            REM on the divide engine; otherwise 111 is reserved and yields 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_MUL = 3'b010;
  localparam logic [2:0] c_OP_DIV = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_OR  = 3'b101;
  localparam logic [2:0] c_OP_XOR = 3'b110;
`ifdef ALU_REM_EN
  localparam logic [2:0] c_OP_REM = 3'b111;
`endif

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Captured operands and iteration state. r_hi/r_lo hold the partial
  // product (MUL) or the partial remainder / dividend-quotient (DIV/REM).
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_zero;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_long;
  logic               w_last;

  logic [WIDTH-1:0]   w_sc_result;
  logic               w_sc_cout;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [WIDTH-1:0]   w_hi_next;
  logic [WIDTH-1:0]   w_lo_next;
  logic [WIDTH-1:0]   w_fin_result;
  logic               w_fin_cout;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.zero      = r_zero;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_is_mul = (bus.opcode == c_OP_MUL);
`ifdef ALU_REM_EN
  assign w_is_div = (bus.opcode == c_OP_DIV) || (bus.opcode == c_OP_REM);
`else
  assign w_is_div = (bus.opcode == c_OP_DIV);
`endif
  // Divide by zero short-circuits to the single-cycle path with the error flag.
  assign w_long = w_is_mul || (w_is_div && (bus.B != '0));
  assign w_last = (r_cnt == c_LAST);

  // Single-cycle results, computed straight from the issuing operands.
  always_comb begin
    w_sc_result = '0;
    w_sc_cout   = 1'b0;
    case (bus.opcode)
      c_OP_ADD: {w_sc_cout, w_sc_result} = {1'b0, bus.A} + {1'b0, bus.B};
      c_OP_SUB: begin
        w_sc_result = bus.A - bus.B;
        w_sc_cout   = (bus.A < bus.B);
      end
      c_OP_DIV: w_sc_cout = 1'b1;
`ifdef ALU_REM_EN
      c_OP_REM: w_sc_cout = 1'b1;
`endif
      c_OP_AND: w_sc_result = bus.A & bus.B;
      c_OP_OR:  w_sc_result = bus.A | bus.B;
      c_OP_XOR: w_sc_result = bus.A ^ bus.B;
      default: begin
        w_sc_result = '0;
        w_sc_cout   = 1'b0;
      end
    endcase
  end

  // One iteration of either engine; MUL shifts right, DIV shifts left.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    // When the trial succeeds the true difference is below r_b, so the
    // low WIDTH bits are exact.
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
    if (r_op == c_OP_MUL) begin
      w_hi_next = w_mul_sum[WIDTH:1];
      w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_next = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  // Result selection on the final iteration edge.
  always_comb begin
    w_fin_cout = (r_op == c_OP_MUL) && (|w_hi_next);
`ifdef ALU_REM_EN
    w_fin_result = (r_op == c_OP_REM) ? w_hi_next : w_lo_next;
`else
    w_fin_result = w_lo_next;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_long ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, engine iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_op  <= bus.opcode;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_is_mul ? bus.B : bus.A;
            if (!w_long) begin
              r_result <= w_sc_result;
              r_cout   <= w_sc_cout;
              r_zero   <= (w_sc_result == '0);
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_fin_result;
            r_cout   <= w_fin_cout;
            r_zero   <= (w_fin_result == '0);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked arithmetic/logic unit. It is the WIDTH-generic successor of the 4-bit registered ALU. ADD/SUB/logic ops complete in one cycle. MUL and DIV run as iterative multi-cycle engines (shift-add multiply, restoring divide). It sits between an operand-issue stage and a result consumer, with valid/ready on both sides.

## Interface
- WIDTH, 8, operand/result width; legal range 2–32
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  unit can accept; high only in IDLE
- A  in  WIDTH  operand A (unsigned)
- B  in  WIDTH  operand B (unsigned)
- opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 REM/reserved
- out_valid  out  1  result/flags valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- cout  out  1  carry / borrow / MUL overflow / divide-by-zero error
- zero  out  1  result == 0

## Operation
- FSM states and transitions:
  - IDLE → BUSY on accept of MUL/DIV/REM with B≠0.
  - IDLE → DONE on accept of any other op, including DIV/REM with B=0.
  - BUSY → DONE after the final iteration.
  - DONE → IDLE when out_ready=1.
- Accept = in_valid & in_ready on a rising edge. A, B and opcode are captured into internal registers at the accept edge. Inputs are ignored at all other times.
- ADD: result = (A+B)[WIDTH-1:0]; cout = carry out of bit WIDTH-1.
- SUB: result = (A−B) mod 2^WIDTH; cout = (A<B).
- MUL: 2·WIDTH-bit product; result = low WIDTH bits; cout = OR of high WIDTH bits.
- DIV: result = quotient; cout = 0.
- REM (only with macro): result = remainder; cout = 0.
- DIV/REM with B=0: result = 0, cout = 1, no iterations.
- AND/OR/XOR: bitwise; cout = 0.
- Opcode 111 without the macro: result = 0, cout = 0, single-cycle.
- zero = (result == 0). It is computed from the final result in the same edge that writes result.
- result, cout and zero are stable for as long as out_valid=1.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, zero=0. Internal accumulators are cleared.
- Reset mid-operation (BUSY or DONE) aborts the operation. The pending result is discarded and not presented after release.
- Single-cycle ops: result, flags and out_valid are registered on the accept edge and visible the following cycle (latency 1).
- MUL/DIV/REM (B≠0): one iteration per edge for WIDTH edges after the accept edge. The WIDTH-th iteration edge writes result and flags and raises out_valid (latency WIDTH+1).
- in_ready = (state==IDLE). No new operand is accepted while BUSY or DONE.
- out_valid with out_ready=0: the unit holds in DONE indefinitely, outputs unchanged.
- The DONE→IDLE transition costs one bubble cycle. Maximum throughput for single-cycle ops is therefore one result per 2 cycles.
- out_ready high while out_valid=0 has no effect.
- in_valid high during BUSY/DONE is not accepted. The upstream must hold it until in_ready=1.

## Configuration
- ALU_REM_EN defined: opcode 111 = REM, using the DIV engine with identical latency. The remainder register is selected at completion.
- ALU_REM_EN undefined: opcode 111 is reserved, completes single-cycle with result=0 and cout=0, and the remainder output mux is not built.

## Test plan
- WIDTH=8, ADD A=200, B=100 → result=44, cout=1, zero=0, out_valid one cycle after accept. SUB A=5, B=5 → result=0, cout=0, zero=1.
- MUL A=16, B=17 → result=16, cout=1. MUL A=15, B=17 → result=255, cout=0. out_valid exactly 9 cycles after the accept edge; in_ready=0 throughout.
- DIV A=200, B=7 → result=28, cout=0 after 9 cycles. DIV A=9, B=0 → result=0, cout=1 in 1 cycle. With ALU_REM_EN: REM A=200, B=7 → result=4.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Result/flags stay constant, in_ready stays 0 and no second op is accepted. Then pulse out_ready → IDLE the next cycle.
- Pulse rst_n low during the 4th MUL iteration → all outputs reset immediately. After release, in_ready=1 and no out_valid appears for the aborted op.
- Opcode 111 without ALU_REM_EN, A=0xFF, B=0x01 → result=0, cout=0, zero=1, latency 1.
